// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA raster bundle passed between video pipeline stages
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster counters, sync pulses and blanking flags
module vga_timing_gen #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BP       = 23,
   parameter bit H_SYNC_POL = 1'b1,
   parameter bit V_SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pix_en,
   vga_if.out   vga_out,
   output logic frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_BLNK = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_BLNK = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [10:0] h_nxt;
   logic [10:0] v_nxt;
   logic        hsync_q;
   logic        vsync_q;
   logic        hblnk_q;
   logic        vblnk_q;
   logic        hsync_nxt;
   logic        vsync_nxt;
   logic        hblnk_nxt;
   logic        vblnk_nxt;
   logic        wrap_nxt;

   // Flags are decoded from the next counter values so that, once registered,
   // they line up with the counts they describe.
   always_comb begin
      h_nxt    = h_cnt + 11'd1;
      v_nxt    = v_cnt;
      wrap_nxt = 1'b0;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         if (v_cnt == V_LAST) begin
            v_nxt    = '0;
            wrap_nxt = 1'b1;
         end else begin
            v_nxt = v_cnt + 11'd1;
         end
      end
      hblnk_nxt = (h_nxt >= H_BLNK);
      vblnk_nxt = (v_nxt >= V_BLNK);
      hsync_nxt = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_nxt = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hblnk_q     <= 1'b0;
         vblnk_q     <= 1'b0;
         hsync_q     <= ~H_SYNC_POL;
         vsync_q     <= ~V_SYNC_POL;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         hblnk_q     <= hblnk_nxt;
         vblnk_q     <= vblnk_nxt;
         hsync_q     <= hsync_nxt;
         vsync_q     <= vsync_nxt;
         frame_start <= wrap_nxt;
      end else begin
         // Stalled strobes must not stretch the frame marker into a multi-cycle pulse.
         frame_start <= 1'b0;
      end
   end

   assign vga_out.hcount = h_cnt;
   assign vga_out.vcount = v_cnt;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vblnk  = vblnk_q;
   assign vga_out.rgb    = 12'h000;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a raster-position model
module tb_vga_timing_gen;
   localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
   localparam int SVA = 8,  SVF = 1, SVS = 2, SVB = 2;
   localparam int DHT = 1056, DVT = 628;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;

   typedef struct {
      int h;
      int v;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
      bit fs;
   } exp_t;

   typedef struct {
      exp_t d;
      exp_t s;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_en = 1'b0;
   logic fs_a, fs_b, fs_s;

   vga_if vga_a ();
   vga_if vga_b ();
   vga_if vga_s ();

   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .pix_en(pix_en), .vga_out(vga_a), .frame_start(fs_a)
   );

   vga_timing_gen #(.H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)) u_neg (
      .clk(clk), .rst(rst), .pix_en(pix_en), .vga_out(vga_b), .frame_start(fs_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_small (
      .clk(clk), .rst(rst), .pix_en(pix_en), .vga_out(vga_s), .frame_start(fs_s)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   item_t sb[$];

   // Model state: linear pixel index inside the frame, plus the frame marker.
   int p_d = 0, p_s = 0;
   bit f_d = 1'b0, f_s = 1'b0;

   function automatic exp_t decode(int p, bit fs, int ht, int ha, int hf, int hw,
                                   int va, int vf, int vw);
      exp_t e;
      e.h  = p % ht;
      e.v  = p / ht;
      e.hb = (e.h >= ha);
      e.vb = (e.v >= va);
      e.hs = (e.h >= ha + hf) && (e.h < ha + hf + hw);
      e.vs = (e.v >= va + vf) && (e.v < va + vf + vw);
      e.fs = fs;
      return e;
   endfunction

   function automatic exp_t cur_small();
      return decode(p_s, f_s, SHT, SHA, SHF, SHS, SVA, SVF, SVS);
   endfunction

   task automatic cycle(input bit r, input bit en);
      item_t it;
      @(negedge clk);
      rst    = r;
      pix_en = en;
      if (r) begin
         p_d = 0; p_s = 0; f_d = 1'b0; f_s = 1'b0;
      end else if (en) begin
         p_d = (p_d + 1) % (DHT * DVT);
         p_s = (p_s + 1) % (SHT * SVT);
         f_d = (p_d == 0);
         f_s = (p_s == 0);
      end else begin
         f_d = 1'b0; f_s = 1'b0;
      end
      it.d = decode(p_d, f_d, DHT, 800, 40, 128, 600, 1, 4);
      it.s = cur_small();
      sb.push_back(it);
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
      end
   endtask

   initial begin : monitor
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            it = sb.pop_front();
            cyc++;
            chk("def_hcount", int'(vga_a.hcount), it.d.h);
            chk("def_vcount", int'(vga_a.vcount), it.d.v);
            chk("def_hsync",  int'(vga_a.hsync),  int'(it.d.hs));
            chk("def_vsync",  int'(vga_a.vsync),  int'(it.d.vs));
            chk("def_hblnk",  int'(vga_a.hblnk),  int'(it.d.hb));
            chk("def_vblnk",  int'(vga_a.vblnk),  int'(it.d.vb));
            chk("def_rgb",    int'(vga_a.rgb),    0);
            chk("def_frame",  int'(fs_a),         int'(it.d.fs));
            chk("neg_hcount", int'(vga_b.hcount), it.d.h);
            chk("neg_hsync",  int'(vga_b.hsync),  int'(!it.d.hs));
            chk("neg_vsync",  int'(vga_b.vsync),  int'(!it.d.vs));
            chk("sml_hcount", int'(vga_s.hcount), it.s.h);
            chk("sml_vcount", int'(vga_s.vcount), it.s.v);
            chk("sml_hsync",  int'(vga_s.hsync),  int'(it.s.hs));
            chk("sml_vsync",  int'(vga_s.vsync),  int'(it.s.vs));
            chk("sml_hblnk",  int'(vga_s.hblnk),  int'(it.s.hb));
            chk("sml_vblnk",  int'(vga_s.vblnk),  int'(it.s.vb));
            chk("sml_frame",  int'(fs_s),         int'(it.s.fs));
         end
      end
   end

   initial begin : stimulus
      exp_t e;
      bit   found;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      // Walk the default raster up to h=1055, then stall twice across the wrap.
      for (int i = 0; i < DHT - 1; i++) cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 6000; i++)
         cycle($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0);
      // Hit reset while the small raster is inside both sync pulses.
      found = 1'b0;
      for (int i = 0; i < 4 * SHT * SVT && !found; i++) begin
         e = cur_small();
         if (e.h == SHA + SHF + 1 && e.v == SVA + SVF + 1) found = 1'b1;
         else cycle(1'b0, 1'b1);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_in_sync_search: got timeout expected sync position reached");
      end
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 3 * SHT * SVT; i++) cycle(1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
